hs_to_vr_bridge: RTL and testbench
==================================

# hs_to_vr_bridge

Converts a 4-phase req/ack handshake stream into a valid/ready stream. It accepts words from a req/ack sender, buffers them in a small synchronous FIFO, and presents them to a valid/ready consumer. It is the return-path counterpart of the existing valid/ready-to-req/ack bridge, and the two can be chained back to back. Data width comes from the shared `WIDTH` define in `defines.sv`.

## Interface
Parameters:
- DEPTH, 4: FIFO depth in words; power of two, ≥ 2.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  accept enable; when low, no new handshake is started.
- req  in  1  handshake request from sender; held high until ack seen high, then dropped.
- data_in  in  `WIDTH`  sender data; stable while req is high.
- ack  out  1  handshake acknowledge; registered.
- valid  out  1  output word available.
- ready  in  1  consumer can take a word.
- data_out  out  `WIDTH`  FIFO head word; forced to 0 when valid is 0.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Receive FSM, two states:
  - IDLE: ack=0. Move to ACK when req_s & en & !full; the FIFO write of data_in happens on that same edge.
  - ACK: ack=1. Return to IDLE when req_s=0. en going low while in ACK does not abort; the FSM still waits for req to drop.
- req_s is req itself, or the synchronized req when the macro below is set.
- Exactly one FIFO write per 4-phase transaction. A req held high across many cycles writes once.
- FIFO is first-word-fall-through:
  - valid = !empty.
  - data_out = head word.
  - pop on valid & ready.
- Occupancy: level = writes − pops. A simultaneous write and pop leaves level unchanged.
- Full: a req arriving at full stays un-acked (FSM remains in IDLE). It is accepted on the first edge where !full.
- Empty: valid=0, data_out=0, and ready is ignored.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. full is level==DEPTH; empty is level==0.
- Reset (any time, including mid-handshake):
  - ack=0, valid=0, data_out=0, level=0, FSM=IDLE, pointers=0, synchronizer flops=0.
  - Buffered words are discarded. A sender caught mid-handshake restarts after seeing ack low.

## Timing
- req high sampled at edge N (macro off) → ack=1 after edge N; word is written at N; valid=1 after N.
- req low sampled at edge M → ack=0 after edge M.
- Minimum transaction is 2 cycles (req high 1 cycle, low 1 cycle), giving a peak rate of 1 word per 2 cycles.
- Output pop: valid & ready at edge K → next head is visible after K. With a continuously ready consumer, throughput is limited only by the input side.
- With `HS_REQ_SYNC_EN`, both the rising and falling response of ack are delayed by 2 cycles.

## Configuration
- `HS_REQ_SYNC_EN` defined: req passes through a 2-flop synchronizer (reset to 0) before the FSM. data_in is still sampled directly, which is safe because the 4-phase protocol guarantees data is stable while req is high. Use this when the sender sits in another clock domain.
- Undefined: req_s = req, with no added latency. The sender must be synchronous to clk.

## Structure
- Shared package `bridge_pkg`:
  - `typedef enum logic {RX_IDLE=1'b0, RX_ACK=1'b1} rx_state_t`.
  - Synchronizer stage count constant `HS_SYNC_STAGES = 2`.
- Sub-module `hs_rx_fifo`:
  - Parameters: DEPTH.
  - Ports: clk, rst, wr_en, rd_en, data_in, data_out (FWFT), full, empty, level.
- Top level contains the synchronizer, the FSM, and the output zero-forcing.

## Test plan
- Single transfer: req=1 with data_in=0xA5 for 3 cycles, then req=0, ready=1 → ack rises 1 cycle after req and falls 1 cycle after req drops; one valid beat with data_out=0xA5; level returns to 0.
- Back-pressure to full (DEPTH=4): ready=0, send 0x01–0x05 → first four acked; fifth req stays un-acked with level=4. Assert ready for 1 cycle → 0x01 popped, fifth write accepted, ack rises, level stays 4.
- Wrap-around: 10 transactions 0x10–0x19 with ready toggling every cycle → data_out order is 0x10..0x19 with no loss or duplication.
- Simultaneous events: at level=2, the input write and output pop land on the same edge → level stays 2 and data order is preserved.
- en gating and reset mid-handshake:
  - en=0 with req=1 → ack stays 0 and nothing is written. Raise en=1 → ack next cycle.
  - rst=0 while ack=1 with level=3 → ack, valid, level go to 0 immediately. A new transaction after reset works.
- `HS_REQ_SYNC_EN` build: repeat the single-transfer test → ack rises 3 cycles after req and falls 3 cycles after req drops; data 0xA5 is delivered intact.

Source files
------------

// File: rtl/bridge_pkg.sv
// rtl/bridge_pkg.sv - shared types and constants for the handshake bridges
package bridge_pkg;

    typedef enum logic {RX_IDLE = 1'b0, RX_ACK = 1'b1} rx_state_t;

    localparam int HS_SYNC_STAGES = 2;

endpackage

// File: rtl/defines.sv
// rtl/defines.sv - shared data width for the req/ack and valid/ready bridges
`ifndef WIDTH
`define WIDTH 8
`endif

// File: rtl/hs_rx_fifo.sv
// rtl/hs_rx_fifo.sv - first-word-fall-through receive FIFO with occupancy count
`ifndef WIDTH
`define WIDTH 8
`endif

module hs_rx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic                      rd_en,
    input  logic [`WIDTH-1:0]         data_in,
    output logic [`WIDTH-1:0]         data_out,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [`WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       level_q, level_d;
    logic              do_wr, do_rd;

    assign full  = (level_q == FULL_LEVEL);
    assign empty = (level_q == '0);
    assign level = level_q;

    // Guard both sides here so the pointers can never overrun regardless of caller.
    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;

    assign data_out = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_wr, do_rd})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

endmodule

// File: rtl/hs_to_vr_bridge.sv
// rtl/hs_to_vr_bridge.sv - 4-phase req/ack to valid/ready bridge; HS_REQ_SYNC_EN adds a req synchronizer
`ifndef WIDTH
`define WIDTH 8
`endif

module hs_to_vr_bridge
    import bridge_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      req,
    input  logic [`WIDTH-1:0]         data_in,
    output logic                      ack,
    output logic                      valid,
    input  logic                      ready,
    output logic [`WIDTH-1:0]         data_out,
    output logic [$clog2(DEPTH):0]    level
);

    rx_state_t         state_q, state_d;
    logic              req_s;
    logic              wr_en;
    logic              rd_en;
    logic              full;
    logic              empty;
    logic [`WIDTH-1:0] fifo_data;

`ifdef HS_REQ_SYNC_EN
    logic [HS_SYNC_STAGES-1:0] sync_q, sync_d;

    assign sync_d = {sync_q[HS_SYNC_STAGES-2:0], req};
    assign req_s  = sync_q[HS_SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end
`else
    assign req_s = req;
`endif

    // The accepting edge both writes the word and raises ack, so one word per transaction.
    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (req_s && en && !full) begin
                    state_d = RX_ACK;
                    wr_en   = 1'b1;
                end
            end
            RX_ACK: begin
                if (!req_s) begin
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign ack      = (state_q == RX_ACK);
    assign valid    = ~empty;
    assign rd_en    = valid & ready;
    assign data_out = valid ? fifo_data : '0;

    hs_rx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .data_in  (data_in),
        .data_out (fifo_data),
        .full     (full),
        .empty    (empty),
        .level    (level)
    );

endmodule

// File: tb/tb_hs_to_vr_bridge.sv
// tb/tb_hs_to_vr_bridge.sv - directed self-checking bench for hs_to_vr_bridge
`ifndef WIDTH
`define WIDTH 8
`endif

module tb_hs_to_vr_bridge;

`ifdef HS_REQ_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic              clk;
    logic              rst;
    logic              en;
    logic              req;
    logic [`WIDTH-1:0] data_in;
    logic              ack;
    logic              valid;
    logic              ready;
    logic [`WIDTH-1:0] data_out;
    logic [2:0]        level;

    int errors = 0;
    int checks = 0;
    logic mon_en = 1'b0;
    logic [`WIDTH-1:0] got_q[$];

    hs_to_vr_bridge #(.DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .req      (req),
        .data_in  (data_in),
        .ack      (ack),
        .valid    (valid),
        .ready    (ready),
        .data_out (data_out),
        .level    (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_en && valid && ready) got_q.push_back(data_out);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [`WIDTH-1:0] d);
        int n;
        req = 1'b1;
        data_in = d;
        n = 0;
        while (!ack && n < 30) begin tick(); n++; end
        if (!ack) check_eq("send_ack_timeout", 32'(ack), 32'd1);
        req = 1'b0;
        n = 0;
        while (ack && n < 30) begin tick(); n++; end
        if (ack) check_eq("send_release_timeout", 32'(ack), 32'd0);
    endtask

    task automatic pop_expect(input string tag, input logic [`WIDTH-1:0] exp);
        check_eq({tag, "_valid"}, 32'(valid), 32'd1);
        check_eq({tag, "_data"}, 32'(data_out), 32'(exp));
        ready = 1'b1;
        tick();
        ready = 1'b0;
    endtask

    initial begin
        int cnt;
        logic [`WIDTH-1:0] exp_w;
        rst = 1'b0; en = 1'b1; req = 1'b0; data_in = '0; ready = 1'b0;
        repeat (2) tick();
        check_eq("rst_ack", 32'(ack), 32'd0);
        check_eq("rst_valid", 32'(valid), 32'd0);
        check_eq("rst_data", 32'(data_out), 32'd0);
        check_eq("rst_level", 32'(level), 32'd0);
        rst = 1'b1;
        tick();

        // Single transfer with a always-ready consumer
        ready = 1'b1; req = 1'b1; data_in = 8'hA5;
        cnt = 0;
        while (!ack && cnt < 20) begin tick(); cnt++; end
        check_eq("single_ack_rise_lat", 32'(cnt), 32'(LAT));
        check_eq("single_valid", 32'(valid), 32'd1);
        check_eq("single_data", 32'(data_out), 32'hA5);
        check_eq("single_level1", 32'(level), 32'd1);
        tick();
        check_eq("single_popped_valid", 32'(valid), 32'd0);
        check_eq("single_popped_level", 32'(level), 32'd0);
        check_eq("single_empty_data", 32'(data_out), 32'd0);
        tick();
        check_eq("single_ack_held", 32'(ack), 32'd1);
        req = 1'b0;
        cnt = 0;
        while (ack && cnt < 20) begin tick(); cnt++; end
        check_eq("single_ack_fall_lat", 32'(cnt), 32'(LAT));
        ready = 1'b0;

        // Back-pressure to full
        for (int i = 1; i <= 4; i++) send(8'(i));
        check_eq("full_level", 32'(level), 32'd4);
        req = 1'b1; data_in = 8'h05;
        repeat (LAT + 3) tick();
        check_eq("full_no_ack", 32'(ack), 32'd0);
        check_eq("full_level_hold", 32'(level), 32'd4);
        check_eq("full_head", 32'(data_out), 32'h01);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check_eq("full_pop_level", 32'(level), 32'd3);
        check_eq("full_pop_head", 32'(data_out), 32'h02);
        check_eq("full_pop_no_ack_yet", 32'(ack), 32'd0);
        tick();
        check_eq("full_fifth_ack", 32'(ack), 32'd1);
        check_eq("full_fifth_level", 32'(level), 32'd4);
        req = 1'b0;
        cnt = 0;
        while (ack && cnt < 20) begin tick(); cnt++; end
        for (int i = 2; i <= 5; i++) pop_expect($sformatf("full_drain%0d", i), 8'(i));
        check_eq("drained_level", 32'(level), 32'd0);
        check_eq("drained_valid", 32'(valid), 32'd0);
        ready = 1'b1;
        tick();
        check_eq("empty_ready_ignored", 32'(level), 32'd0);
        ready = 1'b0;

        // Wrap-around with a toggling consumer
        got_q.delete();
        mon_en = 1'b1;
        fork
            begin
                for (int i = 0; i < 10; i++) send(8'h10 + 8'(i));
            end
            begin
                repeat (120) begin tick(); ready = ~ready; end
            end
        join
        ready = 1'b1;
        repeat (6) tick();
        mon_en = 1'b0;
        ready = 1'b0;
        check_eq("wrap_count", 32'(got_q.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            exp_w = 8'h10 + 8'(i);
            if (i < got_q.size()) check_eq($sformatf("wrap_word%0d", i), 32'(got_q[i]), 32'(exp_w));
        end

        // Write and pop on the same edge at level 2
        send(8'h20);
        send(8'h21);
        check_eq("simul_pre_level", 32'(level), 32'd2);
        req = 1'b1; data_in = 8'h22;
        repeat (LAT - 1) tick();
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check_eq("simul_ack", 32'(ack), 32'd1);
        check_eq("simul_level", 32'(level), 32'd2);
        req = 1'b0;
        cnt = 0;
        while (ack && cnt < 20) begin tick(); cnt++; end
        pop_expect("simul_w21", 8'h21);
        pop_expect("simul_w22", 8'h22);
        check_eq("simul_end_level", 32'(level), 32'd0);

        // en gating
        en = 1'b0; req = 1'b1; data_in = 8'h33;
        repeat (5) tick();
        check_eq("en_low_ack", 32'(ack), 32'd0);
        check_eq("en_low_level", 32'(level), 32'd0);
        en = 1'b1;
        cnt = 0;
        while (!ack && cnt < 20) begin tick(); cnt++; end
        check_eq("en_high_ack_lat", 32'(cnt), 32'd1);
        check_eq("en_high_level", 32'(level), 32'd1);
        en = 1'b0;
        req = 1'b0;
        cnt = 0;
        while (ack && cnt < 20) begin tick(); cnt++; end
        check_eq("en_low_in_ack_release", 32'(ack), 32'd0);
        en = 1'b1;

        // Reset in the middle of a handshake
        send(8'h34);
        req = 1'b1; data_in = 8'h35;
        cnt = 0;
        while (!ack && cnt < 20) begin tick(); cnt++; end
        check_eq("midrst_pre_ack", 32'(ack), 32'd1);
        check_eq("midrst_pre_level", 32'(level), 32'd3);
        #2;
        rst = 1'b0;
        #1;
        check_eq("midrst_ack", 32'(ack), 32'd0);
        check_eq("midrst_valid", 32'(valid), 32'd0);
        check_eq("midrst_level", 32'(level), 32'd0);
        check_eq("midrst_data", 32'(data_out), 32'd0);
        req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        send(8'h77);
        check_eq("postrst_valid", 32'(valid), 32'd1);
        check_eq("postrst_data", 32'(data_out), 32'h77);
        check_eq("postrst_level", 32'(level), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
